// File: rtl/fsm_seq_gen.sv
// Frame serializer: sends 1..8 payload bits MSB first on w, flags runs of
// four or more equal bits within a frame, and pulses done after the last bit.
//
// Output timing: every output is decoded from registered state. w/valid carry
// one payload bit per cycle while in SEND. done is high for the one DONE cycle.
// Requests are not queued: start is only looked at while IDLE.
module fsm_seq_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    input  logic [3:0] len,
    output logic       w,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic       run_flag,
    output logic [1:0] y
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_bit_q, last_bit_d;
    logic [2:0]  run_q, run_d;

    logic [3:0]  eff_len;
    logic [2:0]  cur_run;

    // Effective length: 0 and anything above 8 send a full byte.
    always_comb begin
        eff_len = len;
        if (len == 4'd0 || len > 4'd8) begin
            eff_len = 4'd8;
        end
    end

    // Run length including the bit on w now; run_q==0 marks the first bit.
    always_comb begin
        cur_run = 3'd1;
        if (run_q != 3'd0 && shreg_q[7] == last_bit_q) begin
            cur_run = (run_q >= 3'd4) ? 3'd4 : run_q + 3'd1;
        end
    end

    // Next-state logic and output decode.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        last_bit_d = last_bit_q;
        run_d      = run_q;
        w          = 1'b0;
        valid      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        run_flag   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d    = data;
                    cnt_d      = eff_len;
                    last_bit_d = 1'b0;
                    run_d      = 3'd0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                w          = shreg_q[7];
                valid      = 1'b1;
                busy       = 1'b1;
                run_flag   = (cur_run >= 3'd4);
                shreg_d    = {shreg_q[6:0], 1'b0};
                cnt_d      = cnt_q - 4'd1;
                last_bit_d = shreg_q[7];
                run_d      = cur_run;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign y = state_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            shreg_q    <= 8'd0;
            cnt_q      <= 4'd0;
            last_bit_q <= 1'b0;
            run_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            last_bit_q <= last_bit_d;
            run_q      <= run_d;
        end
    end

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Directed bench for fsm_seq_gen with hand-computed bit and flag patterns.
module tb_fsm_seq_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic [3:0] len;
  logic       w;
  logic       valid;
  logic       busy;
  logic       done;
  logic       run_flag;
  logic [1:0] y;

  int n_cmp;
  int n_bad;

  fsm_seq_gen dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data     (data),
    .len      (len),
    .w        (w),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .run_flag (run_flag),
    .y        (y)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // compare {w, valid, busy, done, run_flag, y}
  task automatic check(input string tag, input logic exp_w, input logic exp_v,
                       input logic exp_b, input logic exp_d, input logic exp_r,
                       input logic [1:0] exp_y);
    logic [6:0] obs;
    logic [6:0] exp;
    obs = {w, valid, busy, done, run_flag, y};
    exp = {exp_w, exp_v, exp_b, exp_d, exp_r, exp_y};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got w/v/b/d/r/y=%b required %b", tag, obs, exp);
    end
  endtask

  // check n payload bits (first bit at index 7), then DONE, then IDLE
  task automatic send_bits(input string tag, input logic [7:0] bits,
                           input logic [7:0] flags, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_bit%0d", tag, i), bits[7-i], 1'b1, 1'b1, 1'b0,
            flags[7-i], 2'd1);
      step();
    end
    check({tag, "_done"}, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
    step();
    check({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  // request one frame from IDLE and check it through to IDLE
  task automatic frame(input string tag, input logic [7:0] d, input logic [3:0] l,
                       input logic [7:0] bits, input logic [7:0] flags, input int n);
    start = 1'b1;
    data  = d;
    len   = l;
    step();
    start = 1'b0;
    send_bits(tag, bits, flags, n);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    start = 1'b0;
    data  = 8'h00;
    len   = 4'd0;
    step();
    step();
    check("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    step();
    check("idle_no_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // F0, len 0 -> 8 bits, runs flagged on bits 3 and 7
    frame("f0", 8'hF0, 4'd0, 8'hF0, 8'b0001_0001, 8);
    // A5, len 8 -> alternating-ish, no runs; busy for 8 SEND + 1 DONE
    frame("a5", 8'hA5, 4'd8, 8'hA5, 8'h00, 8);
    // FF len 6 then 00 len 4: run restarts at the new frame
    frame("ff6", 8'hFF, 4'd6, 8'hFF, 8'b0001_1100, 6);
    frame("004", 8'h00, 4'd4, 8'h00, 8'b0001_0000, 4);
    // short frame and clamped length
    frame("e03", 8'hE0, 4'd3, 8'hE0, 8'h00, 3);
    frame("len12", 8'h96, 4'd12, 8'h96, 8'h00, 8);
    frame("len1", 8'h80, 4'd1, 8'h80, 8'h00, 1);

    // start held high: SEND x8, DONE, IDLE, SEND...; data change after capture
    start = 1'b1;
    data  = 8'hC3;
    len   = 4'd8;
    step();
    data  = 8'h3C;
    send_bits("hold1", 8'hC3, 8'b0000_0100, 8);
    step();
    start = 1'b0;
    send_bits("hold2", 8'h3C, 8'b0000_0100, 8);

    // reset during bit 3 of an F0 frame
    start = 1'b1;
    data  = 8'hF0;
    len   = 4'd0;
    step();
    start = 1'b0;
    check("rst_b0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
    step();
    step();
    step();
    check("rst_b3", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1);
    reset = 1'b0;
    step();
    check("rst_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    step();
    check("rst_stay1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    step();
    check("rst_stay2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // reset has priority over start
    reset = 1'b0;
    start = 1'b1;
    step();
    check("rst_prio", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    start = 1'b0;
    step();
    check("rst_prio_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

    // fresh frame after reset restarts cleanly
    frame("post_rst", 8'h0F, 4'd5, 8'h0F, 8'b0001_0000, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsm_seq_gen.md
FSM_SEQ_GEN -- requirements
Module: fsm_seq_gen

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004 start  input  1  frame request, sampled only in IDLE.
REQ-005 data  input  8  frame payload, transmitted MSB first, captured when start is accepted.
REQ-006 len  input  4  frame length in bits, captured with data: 1..8 used as given, 0 means 8, and 9..15 are clamped to 8.
REQ-007 w  output  1  serial bit stream, the same signal the sequence-detector FSM consumes.
REQ-008 valid  output  1  high while w carries a payload bit.
REQ-009 busy  output  1  high in SEND and DONE.
REQ-010 done  output  1  single-cycle pulse after the last bit.
REQ-011 run_flag  output  1  high when the current bit completes a run of 4 or more equal bits within the frame.
REQ-012 y  output  2  current state code.

Function
REQ-013 States and codes SHALL be: IDLE=0, SEND=1, DONE=2; code 3 is unused and SHALL return to IDLE on the next edge.
REQ-014 In IDLE with start=1, the block SHALL load data into an 8-bit shift register, load the effective length into a 4-bit count, clear the run tracker, and go to SEND; otherwise it SHALL stay in IDLE.
REQ-015 In SEND, w SHALL equal shift-register bit 7 and valid SHALL be 1.
REQ-016 In SEND, each edge SHALL shift the register left by one with zero fill and decrement the count.
REQ-017 SEND SHALL go to DONE on the edge where the count equals 1; otherwise it SHALL stay in SEND.
REQ-018 Latency: with start accepted at edge k, bit i (i = 0..n-1) SHALL be presented in the cycle after edge k+i, and done SHALL be high in the cycle after edge k+n.
REQ-019 DONE SHALL last exactly one cycle, with done=1, w=0 and valid=0, then go to IDLE unconditionally.
REQ-020 start SHALL be ignored in SEND and DONE; requests are not queued.
REQ-021 Consecutive frames SHALL be separated by at least one DONE cycle and one IDLE cycle, even when start is held high.
REQ-022 Outside SEND, w and valid SHALL be 0.
REQ-023 The run tracker SHALL hold the last emitted bit value plus a 3-bit run length that saturates at 4.
REQ-024 On each valid bit, the run length SHALL become min(run+1, 4) if the bit equals the previous bit, and 1 otherwise.
REQ-025 The first bit of a frame SHALL always start a new run of length 1.
REQ-026 run_flag SHALL be combinational from the current bit and the tracker: high exactly when valid=1 and the run length including the current bit is 4 or more.
REQ-027 Within a frame, run_flag SHALL track the detector's z with one cycle less delay.
REQ-028 busy SHALL be 1 exactly when y is SEND or DONE.

Reset
REQ-029 When reset=0 at a rising edge, the block SHALL enter IDLE regardless of state.
REQ-030 After that edge, w, valid, busy, done, run_flag and y SHALL all be 0, and the shift register, count and run tracker SHALL all be cleared.
REQ-031 A frame interrupted by reset SHALL be abandoned with no done pulse; a new start is required after reset returns to 1.
REQ-032 reset=0 SHALL take priority over start in the same cycle.

Verification
REQ-033 data=8'hF0, len=0 -> w=1,1,1,1,0,0,0,0 on 8 consecutive valid cycles; run_flag=1 on bits 3 and 7 only; done=1 one cycle after bit 7.
REQ-034 data=8'hA5, len=8 -> w=1,0,1,0,0,1,0,1; run_flag never 1; busy high for 9 cycles.
REQ-035 data=8'hFF, len=6 -> six 1s; run_flag=1 on bits 3, 4 and 5; then data=8'h00, len=4 as the next frame -> run_flag=1 on bit 3 only, showing the run does not carry across frames.
REQ-036 data=8'hE0, len=3 -> w=1,1,1 then done; run_flag=0; len=12 -> 8 bits sent.
REQ-037 start held high with data=8'hC3, len=8 -> frames repeat with the pattern SEND x8, DONE, IDLE, SEND...; a data change mid-frame does not affect the bits already sent.
REQ-038 reset=0 during bit 3 of an 8'hF0 frame -> at the next edge all outputs are 0 and y=0, with no done pulse; start=0 after reset -> block stays in IDLE.
